// File: rtl/clock_period_monitor_if.sv
// Bundle between the clock period monitor and whatever consumes its results.
//
// Handshake: there is no ready. rise_pulse and fall_pulse are single-cycle
// valid strobes that the consumer must sample on every clk_in rising edge.
// period is meaningful only while period_valid is high. locked and timeout
// are level outputs. state_dbg mirrors the internal FSM state
// (0=IDLE, 1=FIRST, 2=TRACK, 3=LOCKED).
interface clock_period_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_clk;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [1:0]       state_dbg;

  // Monitor side: observes div_clk, produces measurements.
  modport master (
    input  div_clk,
    output rise_pulse, fall_pulse, period, high_time,
    output period_valid, locked, timeout, state_dbg
  );

  // Consumer side: supplies div_clk, reads measurements.
  modport slave (
    output div_clk,
    input  rise_pulse, fall_pulse, period, high_time,
    input  period_valid, locked, timeout, state_dbg
  );
endinterface

// File: rtl/clock_period_monitor.sv
// Measures the period and high time of an asynchronous divided clock in
// clk_in cycles and reports when the period has been stable long enough
// to be considered locked.
module clock_period_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  clock_period_monitor_if.master mon
);
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             s1, s2, prev;
  logic             rise, fall;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] period_r, high_time_r;
  logic [MC_W-1:0]  match_cnt, match_nxt;
  logic             period_valid_r, timeout_r;
  logic             per_sat, tmo_evt, match;
  logic [CNT_W:0]   diff;

  assign rise    = s2 & ~prev;
  assign fall    = ~s2 & prev;
  assign per_sat = (per_cnt == CNT_MAX);
  // A rising edge on the saturating cycle wins over the timeout.
  assign tmo_evt = per_sat & ~rise;

  // Absolute difference one bit wider than the counters so it never wraps.
  assign diff = (per_cnt >= period_r) ? ({1'b0, per_cnt} - {1'b0, period_r})
                                      : ({1'b0, period_r} - {1'b0, per_cnt});
  assign match = (diff <= TOL_W);
  assign match_nxt = !match                ? '0 :
                     (match_cnt >= MC_LOCK) ? MC_LOCK :
                                              match_cnt + MC_W'(1);

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: timeout forces IDLE, otherwise advance on rising edges.
  always_comb begin
    state_nxt = state;
    if (tmo_evt) begin
      state_nxt = IDLE;
    end else if (rise) begin
      case (state)
        IDLE:    state_nxt = FIRST;
        FIRST:   state_nxt = TRACK;
        TRACK:   if (match && (match_nxt == MC_LOCK)) state_nxt = LOCKED;
        LOCKED:  if (!match) state_nxt = TRACK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Synchronizer, edge history and free-running measurement counters.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      prev        <= 1'b0;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      high_time_r <= '0;
    end else begin
      s1   <= mon.div_clk;
      s2   <= s1;
      prev <= s2;
      if (rise)          per_cnt <= CNT_W'(1);
      else if (!per_sat) per_cnt <= per_cnt + CNT_W'(1);
      if (rise)                          hi_cnt <= CNT_W'(1);
      else if (s2 && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_W'(1);
      if (fall) high_time_r <= hi_cnt;
    end
  end

  // Period latch, match counter and status flags driven by FSM events.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      period_r       <= '0;
      period_valid_r <= 1'b0;
      match_cnt      <= '0;
      timeout_r      <= 1'b0;
    end else if (tmo_evt) begin
      timeout_r      <= 1'b1;
      period_valid_r <= 1'b0;
      match_cnt      <= '0;
    end else if (rise) begin
      case (state)
        IDLE: timeout_r <= 1'b0;
        FIRST: begin
          period_r       <= per_cnt;
          period_valid_r <= 1'b1;
          match_cnt      <= '0;
        end
        default: begin
          period_r  <= per_cnt;
          match_cnt <= match_nxt;
        end
      endcase
    end
  end

  // Output logic: locked is a decode of the registered state.
  always_comb begin
    mon.rise_pulse   = rise;
    mon.fall_pulse   = fall;
    mon.period       = period_r;
    mon.high_time    = high_time_r;
    mon.period_valid = period_valid_r;
    mon.timeout      = timeout_r;
    mon.locked       = (state == LOCKED);
    mon.state_dbg    = state;
  end
endmodule
